// File: rtl/change_dispenser.sv
// Coin hopper driver: ejects the owed change coin by coin, confirms each via the
// synchronised hopper sensor, retries on timeout. Optional stats: CHANGE_DISP_STATS_EN.
module change_dispenser #(
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] change_in,
  input  logic       change_valid,
  input  logic       coin_sense,
  input  logic       fault_clr,
  output logic       eject,
  output logic       busy,
  output logic       done,
  output logic       fault,
`ifdef CHANGE_DISP_STATS_EN
  output logic [7:0] coins_total,
  output logic [7:0] retry_total,
`endif
  output logic [2:0] remaining
);

  localparam int CMAX_A = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CMAX   = (CMAX_A > TIMEOUT_CYC) ? CMAX_A : TIMEOUT_CYC;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int RW     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_WAIT, S_GAP, S_DONE, S_FAULT
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   retry_q;
  logic [2:0]      remaining_q;
  logic            eject_q, busy_q, done_q, fault_q;
  logic            sync1_q, sync2_q, sense_prev_q;
  logic            sense_rise, coin_evt, timeout_evt, retry_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sense_prev_q <= 1'b0;
    end else begin
      sync1_q      <= coin_sense;
      sync2_q      <= sync1_q;
      sense_prev_q <= sync2_q;
    end
  end

  assign sense_rise  = sync2_q & ~sense_prev_q;
  // Edges only count while a coin is actually in flight; elsewhere they are noise.
  assign coin_evt    = sense_rise && (state_q == S_PULSE || state_q == S_WAIT) &&
                       (remaining_q != '0);
  assign timeout_evt = (state_q == S_WAIT) && !sense_rise && (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign retry_evt   = timeout_evt && (retry_q < RW'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      remaining_q <= '0;
      eject_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (change_valid) begin
            if (change_in != '0) begin
              remaining_q <= change_in;
              retry_q     <= '0;
              cnt_q       <= '0;
              eject_q     <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= S_PULSE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_PULSE, S_WAIT: begin
          if (coin_evt) begin
            remaining_q <= remaining_q - 3'd1;
            retry_q     <= '0;
            cnt_q       <= '0;
            eject_q     <= 1'b0;
            if (remaining_q == 3'd1) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_GAP;
            end
          end else if (state_q == S_PULSE) begin
            if (cnt_q == CW'(PULSE_CYC - 1)) begin
              cnt_q   <= '0;
              eject_q <= 1'b0;
              state_q <= S_WAIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (timeout_evt) begin
            cnt_q <= '0;
            if (retry_evt) begin
              retry_q <= retry_q + 1'b1;
              eject_q <= 1'b1;
              state_q <= S_PULSE;
            end else begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == CW'(GAP_CYC - 1)) begin
            cnt_q   <= '0;
            eject_q <= 1'b1;
            state_q <= S_PULSE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_FAULT: begin
          if (fault_clr) begin
            fault_q     <= 1'b0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CHANGE_DISP_STATS_EN
  logic [7:0] coins_total_q, retry_total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coins_total_q <= '0;
      retry_total_q <= '0;
    end else begin
      if (coin_evt && coins_total_q != '1) coins_total_q <= coins_total_q + 8'd1;
      if (retry_evt && retry_total_q != '1) retry_total_q <= retry_total_q + 8'd1;
    end
  end

  assign coins_total = coins_total_q;
  assign retry_total = retry_total_q;
`endif

  assign eject     = eject_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench: a timeline model derived from the dispenser's timing rules is
// built up front, then the DUT is compared against it on every cycle.
module tb_change_dispenser;

  localparam int P  = 4;
  localparam int G  = 2;
  localparam int T  = 64;
  localparam int MR = 2;
  localparam int N  = 460;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] change_in;
  logic       change_valid, coin_sense, fault_clr;
  logic       eject, busy, done, fault;
  logic [2:0] remaining;
`ifdef CHANGE_DISP_STATS_EN
  logic [7:0] coins_total, retry_total;
`endif

  change_dispenser #(
    .PULSE_CYC(P), .GAP_CYC(G), .TIMEOUT_CYC(T), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .change_in(change_in), .change_valid(change_valid),
    .coin_sense(coin_sense), .fault_clr(fault_clr), .eject(eject), .busy(busy),
    .done(done), .fault(fault),
`ifdef CHANGE_DISP_STATS_EN
    .coins_total(coins_total), .retry_total(retry_total),
`endif
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Stimulus timeline: index c is applied before, and its outputs observed after, edge c.
  bit         s_cv[N], s_sense[N], s_fclr[N], s_rst[N];
  logic [2:0] s_cin[N];
  bit         e_ej[N], e_bz[N], e_dn[N], e_ft[N];
  logic [2:0] e_rm[N];
  bit         ev_coin[N], ev_retry[N];
  int         e_coins[N], e_retries[N];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int c, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, c, got, exp);
    end
  endtask

  task automatic fill(input int a, input int b, input bit ej, input bit bz,
                      input bit dn, input bit ft, input logic [2:0] rm);
    for (int i = a; i < b; i++) begin
      e_ej[i] = ej; e_bz[i] = bz; e_dn[i] = dn; e_ft[i] = ft; e_rm[i] = rm;
    end
  endtask

  // One request: coin 0 stays unanswered for sil0 attempts; answered coins see the
  // sensor pin 5 cycles after eject falls, counted 2 edges later.
  task automatic req(input int c, input int n, input int sil0, input int fdly,
                     input bit spur, output int fin);
    int t, f, a;
    logic [2:0] rem;
    s_cv[c] = 1'b1; s_cin[c] = 3'(n); fin = c + 1;
    if (n == 0) begin
      e_dn[c] = 1'b1;
      return;
    end
    t = c; rem = 3'(n);
    for (int i = 0; i < n; i++) begin
      for (int at = 0; at <= MR; at++) begin
        fill(t, t + P, 1'b1, 1'b1, 1'b0, 1'b0, rem);
        f = t + P;
        if (i == 0 && at < sil0) begin
          fill(f, f + T, 1'b0, 1'b1, 1'b0, 1'b0, rem);
          if (at == MR) begin
            fin = f + T + fdly;
            fill(f + T, fin, 1'b0, 1'b1, 1'b0, 1'b1, rem);
            s_fclr[fin] = 1'b1;
            return;
          end
          t = f + T;
          ev_retry[t] = 1'b1;
        end else begin
          s_sense[f + 5] = 1'b1;
          a = f + 7;
          fill(f, a, 1'b0, 1'b1, 1'b0, 1'b0, rem);
          rem = rem - 3'd1;
          ev_coin[a] = 1'b1;
          if (rem == 3'd0) begin
            fill(a, a + 1, 1'b0, 1'b1, 1'b1, 1'b0, rem);
            fin = a + 1;
            return;
          end
          fill(a, a + G, 1'b0, 1'b1, 1'b0, 1'b0, rem);
          if (spur) s_sense[a] = 1'b1;
          t = a + G;
          break;
        end
      end
    end
  endtask

  task automatic build();
    int fin, cc, cr;
    for (int i = 0; i < N; i++) begin s_cin[i] = '0; e_rm[i] = '0; end
    s_rst[0] = 1'b1; s_rst[1] = 1'b1; s_rst[2] = 1'b1;
    req(10, 3, 0, 0, 1'b0, fin);        // three coins, prompt sensor
    s_fclr[52] = 1'b1;                  // fault_clr while idle: no effect
    req(55, 0, 0, 0, 1'b0, fin);        // zero change
    req(60, 2, 3, 6, 1'b0, fin);        // silent hopper -> fault, then clear
    req(280, 1, 1, 0, 1'b0, fin);       // one timeout, answered on retry
    s_cv[370] = 1'b1; s_cin[370] = 3'd5;  // reset mid-pulse
    fill(370, 372, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
    s_rst[372] = 1'b1; s_rst[373] = 1'b1;
    req(380, 1, 0, 0, 1'b0, fin);       // normal request after reset
    req(400, 3, 0, 0, 1'b1, fin);       // spurious edges in GAP
    s_cv[405] = 1'b1; s_cin[405] = 3'd5;  // request while WAIT
    s_cv[fin] = 1'b1; s_cin[fin] = 3'd2;  // request while DONE
    s_sense[445] = 1'b1;                // edge while idle
    cc = 0; cr = 0;
    for (int i = 0; i < N; i++) begin
      if (s_rst[i]) begin cc = 0; cr = 0; end
      else begin cc += int'(ev_coin[i]); cr += int'(ev_retry[i]); end
      e_coins[i] = cc; e_retries[i] = cr;
    end
  endtask

  initial begin
    int t1_rises, t1_high, t1_done_at, t3_rises, t4_rises, t6_rises;
    bit prev_ej;
    t1_rises = 0; t1_high = 0; t1_done_at = -1; t3_rises = 0; t4_rises = 0; t6_rises = 0;
    prev_ej = 1'b0;
    change_in = '0; change_valid = 1'b0; coin_sense = 1'b0; fault_clr = 1'b0;
    rst_n = 1'b1;
    build();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_eject", -1, int'(eject), 0);
    chk("rst_async_busy", -1, int'(busy), 0);
    chk("rst_async_rem", -1, int'(remaining), 0);
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      change_valid = s_cv[c];
      change_in    = s_cin[c];
      coin_sense   = s_sense[c];
      fault_clr    = s_fclr[c];
      if (s_rst[c] && rst_n) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_eject", c, int'(eject), 0);
        chk("rst_async_busy", c, int'(busy), 0);
      end
      rst_n = !s_rst[c];
      @(posedge clk);
      #1;
      chk("eject", c, int'(eject), int'(e_ej[c]));
      chk("busy", c, int'(busy), int'(e_bz[c]));
      chk("done", c, int'(done), int'(e_dn[c]));
      chk("fault", c, int'(fault), int'(e_ft[c]));
      chk("remaining", c, int'(remaining), int'(e_rm[c]));
`ifdef CHANGE_DISP_STATS_EN
      chk("coins_total", c, int'(coins_total), e_coins[c]);
      chk("retry_total", c, int'(retry_total), e_retries[c]);
`endif
      if (c >= 10 && c < 50) begin
        if (eject && !prev_ej) t1_rises++;
        if (eject) t1_high++;
        if (done && t1_done_at < 0) t1_done_at = c;
      end
      if (c >= 60 && c < 275 && eject && !prev_ej) t3_rises++;
      if (c >= 280 && c < 365 && eject && !prev_ej) t4_rises++;
      if (c >= 400 && c < N && eject && !prev_ej) t6_rises++;
      prev_ej = eject;
    end
    chk("t1_eject_pulses", 0, t1_rises, 3);
    chk("t1_eject_width", 0, t1_high, 12);
    chk("t1_done_cycle", 0, t1_done_at, 47);
    chk("t3_eject_pulses", 0, t3_rises, 3);
    chk("t4_eject_pulses", 0, t4_rises, 2);
    chk("t6_eject_pulses", 0, t6_rises, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the vending machine controller; consumes its 3-bit change count and physically ejects coins one at a time through a hopper solenoid.
- Ejects each coin, confirms it with the hopper coin sensor, retries on timeout, and reports completion or fault back to the system.
- One clock domain. The coin_sense input is asynchronous and is synchronised inside the block.

Parameters:
- PULSE_CYC, 4: eject solenoid on-time in clk cycles, >=1.
- GAP_CYC, 2: eject off-time between coins in clk cycles, >=1.
- TIMEOUT_CYC, 64: maximum cycles in WAIT for the coin sensor before a retry.
- MAX_RETRY, 2: number of retries allowed per coin before entering FAULT.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- change_in  input  3  number of coins to return (0-7), from the machine's change output.
- change_valid  input  1  one-cycle strobe; change_in is valid on this cycle.
- coin_sense  input  1  asynchronous hopper sensor; high while a coin passes.
- fault_clr  input  1  clears FAULT, returns the block to IDLE.
- eject  output  1  solenoid drive.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a request completes.
- fault  output  1  sticky fault flag.
- remaining  output  3  coins still owed.

Behaviour:
- Reset (async assert, sync release): state=IDLE; eject=0, busy=0, done=0, fault=0, remaining=0; all counters and synchroniser flops cleared.
- coin_sense passes through a 2-flop synchroniser plus an edge register. A coin is counted on the synchronised rising edge only, 3 cycles after the pin rises.
- IDLE:
  - change_valid with change_in!=0: load remaining=change_in and clear the retry count; next cycle enter PULSE.
  - change_valid with change_in==0: done=1 on the next cycle; stay in IDLE.
  - change_valid outside IDLE is ignored; no queueing.
- PULSE: eject=1 for exactly PULSE_CYC cycles, then WAIT. A sensor edge seen during PULSE counts as in WAIT.
- WAIT: eject=0; a cycle counter runs.
  - Sensor edge: remaining decrements; clear retry count and cycle counter. If remaining is now 0, go to DONE, otherwise go to GAP.
  - Counter reaches TIMEOUT_CYC with no edge: if retry<MAX_RETRY, increment retry and return to PULSE. Otherwise go to FAULT.
  - Extra sensor edges in any state other than PULSE/WAIT are ignored; remaining never underflows.
- GAP: eject=0 for GAP_CYC cycles, then PULSE.
- DONE: done=1 for one cycle, busy=0 from the following cycle, then IDLE.
- FAULT:
  - fault=1, eject=0, busy=1; remaining holds the owed count.
  - fault_clr: fault=0, remaining=0, state=IDLE on the next cycle.
  - fault_clr in any other state has no effect.
- Minimum latency for 1 coin, from change_valid to done: 1 + PULSE_CYC + sensor path + 1.
- Reset mid-operation aborts immediately: eject drops asynchronously and the owed count is lost.

Optional Feature:
- Macro CHANGE_DISP_STATS_EN.
- When defined: adds output port coins_total [7:0], a saturating count of successfully sensed coins (holds at 255). Also adds output port retry_total [7:0], a saturating count of timeout retries. Both reset to 0 and are not cleared by fault_clr.
- When undefined: neither port exists and no counter logic is generated.

Test Plan:
- change_in=3 with change_valid, sensor pulses 5 cycles after each eject fall → exactly 3 eject pulses, each PULSE_CYC wide; remaining 3→2→1→0; one done pulse; busy low afterwards.
- change_in=0 with change_valid → done pulses once; eject never asserts; busy stays 0.
- change_in=2, no sensor response for the first coin → 3 eject pulses (1+MAX_RETRY), spaced TIMEOUT_CYC apart; then fault=1 and remaining=2. Assert fault_clr → fault=0, remaining=0, IDLE.
- change_in=1, sensor silent for one timeout then responds on the retry → 2 eject pulses, done=1, fault=0 (retry_total=1 under CHANGE_DISP_STATS_EN).
- rst_n driven low during PULSE with change_in=5 → eject=0 immediately, all outputs at reset values; a new request after release works normally.
- change_valid asserted while busy, plus spurious sensor edges in GAP → request ignored, remaining unaffected, and exactly the original coin count is ejected.
